// File: rtl/slot_scheduler.sv
// slot_scheduler: TDMA frame timer. Divides SYS_CLK into slots and slots into
// frames, aligns to SYNC_IN and tracks lock. It also holds double-buffered TX/RX
// slot configuration that only takes effect at frame boundaries.
module slot_scheduler #(
  parameter int FRAME_LEN = 100,
  parameter int TICK_DIV  = 16,
  parameter int MISS_MAX  = 4
) (
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       START,
  input  logic       SYNC_IN,
  input  logic       CFG_WE,
  input  logic       CFG_SEL,
  input  logic [7:0] CFG_SLOT,
  input  logic       CFG_EN,
  output logic [6:0] TIME,
  output logic [7:0] TX_SLOT,
  output logic [7:0] RX_SLOT,
  output logic       TXSLOT_EN,
  output logic       RXSLOT_EN,
  output logic       FRAME_START,
  output logic       LOCKED,
  output logic       CFG_ERR
);

  localparam int DIV_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int MISS_W = (MISS_MAX < 1) ? 1 : $clog2(MISS_MAX + 1);

  localparam logic [DIV_W-1:0]  LAST_DIV   = DIV_W'(TICK_DIV - 1);
  localparam logic [6:0]        LAST_SLOT  = 7'(FRAME_LEN - 1);
  localparam logic [7:0]        SLOT_LIMIT = 8'(FRAME_LEN);
  localparam logic [MISS_W-1:0] MISS_SAT   = MISS_W'(MISS_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [6:0]        time_reg, time_next;
  logic              fs_reg, fs_next;
  logic              locked_reg, locked_next;
  logic [MISS_W-1:0] miss_reg, miss_next;
  logic              cfg_err_reg, cfg_err_next;

  logic              tick_end;
  logic              frame_end;
  logic [MISS_W-1:0] miss_inc;
  logic              cfg_bad;
  logic              cfg_ok;
  logic              run_next;

  assign tick_end  = (div_reg == LAST_DIV);
  assign frame_end = tick_end && (time_reg == LAST_SLOT);
  assign miss_inc  = miss_reg + 1'b1;
  assign cfg_bad   = (CFG_SLOT >= SLOT_LIMIT);
  assign cfg_ok    = CFG_WE && !cfg_bad;
  assign run_next  = (state_next == RUN);

  // State register
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus next values of slot timing, frame strobe and lock tracking
  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    time_next    = time_reg;
    fs_next      = 1'b0;
    locked_next  = locked_reg;
    miss_next    = miss_reg;
    cfg_err_next = CFG_WE && cfg_bad;
    unique case (state_reg)
      IDLE: begin
        div_next    = '0;
        time_next   = '0;
        locked_next = 1'b0;
        miss_next   = '0;
        if (START) state_next = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        div_next    = '0;
        time_next   = '0;
        locked_next = 1'b0;
        miss_next   = '0;
        if (!START) begin
          state_next = IDLE;
        end else if (SYNC_IN) begin
          state_next  = RUN;
          fs_next     = 1'b1;
          locked_next = 1'b1;
        end
      end
      RUN: begin
        if (!START) begin
          state_next  = IDLE;
          div_next    = '0;
          time_next   = '0;
          locked_next = 1'b0;
          miss_next   = '0;
        end else if (SYNC_IN && !frame_end) begin
          // Misaligned sync: restart the frame immediately and drop lock
          div_next    = '0;
          time_next   = '0;
          fs_next     = 1'b1;
          locked_next = 1'b0;
          miss_next   = '0;
        end else if (tick_end) begin
          div_next = '0;
          if (frame_end) begin
            time_next = '0;
            fs_next   = 1'b1;
            if (SYNC_IN) begin
              locked_next = 1'b1;
              miss_next   = '0;
            end else if (miss_reg != MISS_SAT) begin
              miss_next = miss_inc;
              if (miss_inc == MISS_SAT) locked_next = 1'b0;
            end else begin
              locked_next = 1'b0;
            end
          end else begin
            time_next = time_reg + 7'd1;
          end
        end else begin
          div_next = div_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Timing, strobe and status registers
  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      div_reg     <= '0;
      time_reg    <= '0;
      fs_reg      <= 1'b0;
      locked_reg  <= 1'b0;
      miss_reg    <= '0;
      cfg_err_reg <= 1'b0;
    end else begin
      div_reg     <= div_next;
      time_reg    <= time_next;
      fs_reg      <= fs_next;
      locked_reg  <= locked_next;
      miss_reg    <= miss_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

  // Channel 0 is TX, channel 1 is RX; each has a shadow and an active copy
  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic [7:0] shadow_slot_reg;
    logic       shadow_en_reg;
    logic [7:0] active_slot_reg;
    logic       active_en_reg;
    logic       wr_hit;

    assign wr_hit = cfg_ok && ((gi == 0) ? !CFG_SEL : CFG_SEL);

    // Shadow takes writes any time; active copies the pre-edge shadow only at
    // frame start, so a write landing on that same edge waits a full frame
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
      if (!RST_N) begin
        shadow_slot_reg <= '0;
        shadow_en_reg   <= 1'b0;
        active_slot_reg <= '0;
        active_en_reg   <= 1'b0;
      end else begin
        if (wr_hit) begin
          shadow_slot_reg <= CFG_SLOT;
          shadow_en_reg   <= CFG_EN;
        end
        if (fs_next) begin
          active_slot_reg <= shadow_slot_reg;
          active_en_reg   <= shadow_en_reg;
        end else if (!run_next) begin
          active_en_reg <= 1'b0;
        end
      end
    end
  end

  assign TIME        = time_reg;
  assign FRAME_START = fs_reg;
  assign LOCKED      = locked_reg;
  assign CFG_ERR     = cfg_err_reg;
  assign TX_SLOT     = g_chan[0].active_slot_reg;
  assign TXSLOT_EN   = g_chan[0].active_en_reg;
  assign RX_SLOT     = g_chan[1].active_slot_reg;
  assign RXSLOT_EN   = g_chan[1].active_en_reg;

endmodule

// File: tb/tb_slot_scheduler.sv
// tb_slot_scheduler: scenario tasks with a due-cycle scoreboard for slot_scheduler
// (FRAME_LEN = 10, TICK_DIV = 4, MISS_MAX = 2).
module tb_slot_scheduler;

  logic       SYS_CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       SYNC_IN = 1'b0;
  logic       CFG_WE = 1'b0;
  logic       CFG_SEL = 1'b0;
  logic [7:0] CFG_SLOT = 8'd0;
  logic       CFG_EN = 1'b0;
  logic [6:0] TIME;
  logic [7:0] TX_SLOT;
  logic [7:0] RX_SLOT;
  logic       TXSLOT_EN;
  logic       RXSLOT_EN;
  logic       FRAME_START;
  logic       LOCKED;
  logic       CFG_ERR;

  slot_scheduler #(
    .FRAME_LEN(10),
    .TICK_DIV (4),
    .MISS_MAX (2)
  ) dut (
    .SYS_CLK    (SYS_CLK),
    .RST_N      (RST_N),
    .START      (START),
    .SYNC_IN    (SYNC_IN),
    .CFG_WE     (CFG_WE),
    .CFG_SEL    (CFG_SEL),
    .CFG_SLOT   (CFG_SLOT),
    .CFG_EN     (CFG_EN),
    .TIME       (TIME),
    .TX_SLOT    (TX_SLOT),
    .RX_SLOT    (RX_SLOT),
    .TXSLOT_EN  (TXSLOT_EN),
    .RXSLOT_EN  (RXSLOT_EN),
    .FRAME_START(FRAME_START),
    .LOCKED     (LOCKED),
    .CFG_ERR    (CFG_ERR)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef enum int {S_TIME, S_FS, S_LOCK, S_TXS, S_TXE, S_RXS, S_RXE, S_ERR} sel_t;
  typedef struct {
    int         due;
    sel_t       sel;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  task automatic step();
    @(posedge SYS_CLK);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] sample(input sel_t s);
    logic [7:0] v;
    v = 8'hEE;
    case (s)
      S_TIME: v = {1'b0, TIME};
      S_FS:   v = {7'd0, FRAME_START};
      S_LOCK: v = {7'd0, LOCKED};
      S_TXS:  v = TX_SLOT;
      S_TXE:  v = {7'd0, TXSLOT_EN};
      S_RXS:  v = RX_SLOT;
      S_RXE:  v = {7'd0, RXSLOT_EN};
      S_ERR:  v = {7'd0, CFG_ERR};
      default: v = 8'hEE;
    endcase
    return v;
  endfunction

  // Scoreboard push, kept ordered by due cycle
  task automatic expect_at(input int due, input sel_t sel, input int val, input string tag);
    exp_t item;
    int   i;
    item.due = due;
    item.sel = sel;
    item.val = 8'(val);
    item.tag = tag;
    i = 0;
    while (i < sb.size() && sb[i].due <= due) i++;
    sb.insert(i, item);
  endtask

  // Bring the DUT back to WAIT_SYNC; the caller pulses SYNC_IN at cycle base
  task automatic restart(output int base);
    SYNC_IN = 1'b0;
    CFG_WE  = 1'b0;
    START   = 1'b0;
    step();
    START = 1'b1;
    step();
    base = cyc;
  endtask

  task automatic test_reset();
    logic [7:0] act;
    step();
    step();
    for (int s = 0; s < 8; s++) begin
      act = sample(sel_t'(s));
      total++;
      if (act !== 8'd0) begin
        bad++;
        $display("FAIL reset_out%0d: got %0d expected 0", s, act);
      end else $display("check reset_out%0d ok", s);
    end
    RST_N = 1'b1;
    step();
    step();
    step();
    total++;
    if (TIME !== 7'd0 || FRAME_START !== 1'b0 || LOCKED !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: got time=%0d fs=%0d lock=%0d expected 0/0/0", TIME, FRAME_START, LOCKED);
    end else $display("check idle_hold ok");
  endtask

  task automatic test_start();
    int         base;
    exp_t       e;
    logic [7:0] act;
    START = 1'b1;
    step();
    total++;
    if (LOCKED !== 1'b0 || TIME !== 7'd0) begin
      bad++;
      $display("FAIL wait_sync_out: got lock=%0d time=%0d expected 0/0", LOCKED, TIME);
    end else $display("check wait_sync_out ok");
    // START low wins over a simultaneous SYNC_IN
    START   = 1'b0;
    SYNC_IN = 1'b1;
    step();
    SYNC_IN = 1'b0;
    total++;
    if (FRAME_START !== 1'b0 || LOCKED !== 1'b0) begin
      bad++;
      $display("FAIL start_priority: got fs=%0d lock=%0d expected 0/0", FRAME_START, LOCKED);
    end else $display("check start_priority ok");
    START = 1'b1;
    step();
    base = cyc;
    expect_at(base + 1,  S_TIME, 0, "start_t0");
    expect_at(base + 1,  S_FS,   1, "start_fs0");
    expect_at(base + 1,  S_LOCK, 1, "start_lock");
    expect_at(base + 1,  S_TXE,  0, "start_txe");
    expect_at(base + 2,  S_FS,   0, "start_fs_once");
    expect_at(base + 4,  S_TIME, 0, "start_t0_hold");
    expect_at(base + 5,  S_TIME, 1, "start_t1");
    expect_at(base + 37, S_TIME, 9, "start_t9");
    expect_at(base + 40, S_TIME, 9, "start_t9_hold");
    expect_at(base + 41, S_TIME, 0, "start_wrap");
    expect_at(base + 41, S_FS,   1, "start_fs1");
    expect_at(base + 42, S_FS,   0, "start_fs1_once");
    expect_at(base + 45, S_TIME, 1, "start_t1b");
    while (cyc <= base + 45) begin
      SYNC_IN = (cyc == base);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = sample(e.sel);
        total++;
        if (e.due != cyc || act !== e.val) begin
          bad++;
          $display("FAIL %s at +%0d: got %0d expected %0d", e.tag, e.due - base, act, e.val);
        end else $display("check %s ok", e.tag);
      end
      step();
    end
    SYNC_IN = 1'b0;
  endtask

  task automatic test_reconfig();
    int         base;
    exp_t       e;
    logic [7:0] act;
    restart(base);
    expect_at(base + 1,  S_TXS, 0, "rc_txs_init");
    expect_at(base + 1,  S_TXE, 0, "rc_txe_init");
    expect_at(base + 11, S_TXS, 0, "rc_txs_midframe");
    expect_at(base + 40, S_TXS, 0, "rc_txs_end");
    expect_at(base + 40, S_TXE, 0, "rc_txe_end");
    expect_at(base + 41, S_FS,  1, "rc_fs");
    expect_at(base + 41, S_TXS, 3, "rc_txs_load");
    expect_at(base + 41, S_TXE, 1, "rc_txe_load");
    expect_at(base + 41, S_RXS, 0, "rc_rxs_coincident");
    expect_at(base + 41, S_RXE, 0, "rc_rxe_coincident");
    expect_at(base + 60, S_TXS, 3, "rc_txs_hold");
    expect_at(base + 81, S_TXS, 6, "rc_txs_overwrite");
    expect_at(base + 81, S_TXE, 0, "rc_txe_overwrite");
    expect_at(base + 81, S_RXS, 7, "rc_rxs_next");
    expect_at(base + 81, S_RXE, 1, "rc_rxe_next");
    while (cyc <= base + 81) begin
      SYNC_IN = (cyc == base);
      CFG_WE  = 1'b0;
      case (cyc - base)
        10: begin CFG_WE = 1'b1; CFG_SEL = 1'b0; CFG_SLOT = 8'd3; CFG_EN = 1'b1; end
        40: begin CFG_WE = 1'b1; CFG_SEL = 1'b1; CFG_SLOT = 8'd7; CFG_EN = 1'b1; end
        45: begin CFG_WE = 1'b1; CFG_SEL = 1'b0; CFG_SLOT = 8'd5; CFG_EN = 1'b1; end
        50: begin CFG_WE = 1'b1; CFG_SEL = 1'b0; CFG_SLOT = 8'd6; CFG_EN = 1'b0; end
        default: ;
      endcase
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = sample(e.sel);
        total++;
        if (e.due != cyc || act !== e.val) begin
          bad++;
          $display("FAIL %s at +%0d: got %0d expected %0d", e.tag, e.due - base, act, e.val);
        end else $display("check %s ok", e.tag);
      end
      step();
    end
    CFG_WE = 1'b0;
  endtask

  task automatic test_lost_sync();
    int         base;
    exp_t       e;
    logic [7:0] act;
    restart(base);
    expect_at(base + 41,  S_LOCK, 1, "ls_lock_after1");
    expect_at(base + 80,  S_LOCK, 1, "ls_lock_before2");
    expect_at(base + 80,  S_TIME, 9, "ls_t9");
    expect_at(base + 81,  S_LOCK, 0, "ls_lock_lost");
    expect_at(base + 81,  S_TIME, 0, "ls_t0");
    expect_at(base + 81,  S_FS,   1, "ls_fs");
    expect_at(base + 85,  S_TIME, 1, "ls_t1_free");
    expect_at(base + 121, S_LOCK, 0, "ls_lock_sat");
    expect_at(base + 121, S_FS,   1, "ls_fs_sat");
    while (cyc <= base + 121) begin
      SYNC_IN = (cyc == base);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = sample(e.sel);
        total++;
        if (e.due != cyc || act !== e.val) begin
          bad++;
          $display("FAIL %s at +%0d: got %0d expected %0d", e.tag, e.due - base, act, e.val);
        end else $display("check %s ok", e.tag);
      end
      step();
    end
    SYNC_IN = 1'b0;
  endtask

  task automatic test_reject();
    int         base;
    exp_t       e;
    logic [7:0] act;
    restart(base);
    expect_at(base + 1,  S_TXS, 6, "rj_txs_init");
    expect_at(base + 1,  S_RXE, 1, "rj_rxe_init");
    expect_at(base + 10, S_ERR, 0, "rj_err_idle");
    expect_at(base + 11, S_ERR, 1, "rj_err_slot10");
    expect_at(base + 12, S_ERR, 0, "rj_err_one_cycle");
    expect_at(base + 21, S_ERR, 0, "rj_err_slot9_ok");
    expect_at(base + 26, S_ERR, 1, "rj_err_slot255");
    expect_at(base + 27, S_ERR, 0, "rj_err_clear");
    expect_at(base + 41, S_TXS, 6, "rj_txs_unchanged");
    expect_at(base + 41, S_TXE, 0, "rj_txe_unchanged");
    expect_at(base + 41, S_RXS, 9, "rj_rxs_boundary");
    expect_at(base + 41, S_RXE, 0, "rj_rxe_boundary");
    while (cyc <= base + 41) begin
      SYNC_IN = (cyc == base);
      CFG_WE  = 1'b0;
      case (cyc - base)
        10: begin CFG_WE = 1'b1; CFG_SEL = 1'b0; CFG_SLOT = 8'd10;  CFG_EN = 1'b1; end
        20: begin CFG_WE = 1'b1; CFG_SEL = 1'b1; CFG_SLOT = 8'd9;   CFG_EN = 1'b0; end
        25: begin CFG_WE = 1'b1; CFG_SEL = 1'b0; CFG_SLOT = 8'd255; CFG_EN = 1'b1; end
        default: ;
      endcase
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = sample(e.sel);
        total++;
        if (e.due != cyc || act !== e.val) begin
          bad++;
          $display("FAIL %s at +%0d: got %0d expected %0d", e.tag, e.due - base, act, e.val);
        end else $display("check %s ok", e.tag);
      end
      step();
    end
    CFG_WE = 1'b0;
  endtask

  task automatic test_resync();
    int         base;
    exp_t       e;
    logic [7:0] act;
    restart(base);
    expect_at(base + 22,  S_TIME, 5, "rs_t5");
    expect_at(base + 22,  S_LOCK, 1, "rs_lock_pre");
    expect_at(base + 23,  S_TIME, 0, "rs_mis_t0");
    expect_at(base + 23,  S_FS,   1, "rs_mis_fs");
    expect_at(base + 23,  S_LOCK, 0, "rs_mis_lock");
    expect_at(base + 24,  S_FS,   0, "rs_mis_fs_once");
    expect_at(base + 27,  S_TIME, 1, "rs_t1");
    expect_at(base + 62,  S_TIME, 9, "rs_t9");
    expect_at(base + 62,  S_LOCK, 0, "rs_unlocked");
    expect_at(base + 63,  S_TIME, 0, "rs_al_t0");
    expect_at(base + 63,  S_FS,   1, "rs_al_fs");
    expect_at(base + 63,  S_LOCK, 1, "rs_al_lock");
    expect_at(base + 101, S_TIME, 9, "rs_early_t9");
    expect_at(base + 102, S_TIME, 0, "rs_early_t0");
    expect_at(base + 102, S_LOCK, 0, "rs_early_lock");
    while (cyc <= base + 102) begin
      SYNC_IN = (cyc == base) || (cyc == base + 22) || (cyc == base + 62) || (cyc == base + 101);
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = sample(e.sel);
        total++;
        if (e.due != cyc || act !== e.val) begin
          bad++;
          $display("FAIL %s at +%0d: got %0d expected %0d", e.tag, e.due - base, act, e.val);
        end else $display("check %s ok", e.tag);
      end
      step();
    end
    SYNC_IN = 1'b0;
  endtask

  task automatic test_stop_reset();
    int         base;
    exp_t       e;
    logic [7:0] act;
    CFG_WE = 1'b1; CFG_SEL = 1'b0; CFG_SLOT = 8'd2; CFG_EN = 1'b1;
    step();
    CFG_SEL = 1'b1; CFG_SLOT = 8'd4;
    step();
    CFG_WE = 1'b0;
    restart(base);
    expect_at(base + 1,  S_TXS,  2, "st_txs");
    expect_at(base + 1,  S_TXE,  1, "st_txe");
    expect_at(base + 1,  S_RXS,  4, "st_rxs");
    expect_at(base + 1,  S_RXE,  1, "st_rxe");
    expect_at(base + 15, S_TIME, 3, "st_t3");
    expect_at(base + 16, S_TIME, 0, "st_stop_t0");
    expect_at(base + 16, S_TXE,  0, "st_stop_txe");
    expect_at(base + 16, S_RXE,  0, "st_stop_rxe");
    expect_at(base + 16, S_LOCK, 0, "st_stop_lock");
    expect_at(base + 16, S_TXS,  2, "st_stop_txs_kept");
    expect_at(base + 16, S_RXS,  4, "st_stop_rxs_kept");
    expect_at(base + 21, S_TXE,  0, "st_wait_txe");
    expect_at(base + 26, S_FS,   1, "st_rerun_fs");
    expect_at(base + 26, S_TXE,  1, "st_rerun_txe");
    expect_at(base + 26, S_LOCK, 1, "st_rerun_lock");
    while (cyc <= base + 29) begin
      SYNC_IN = (cyc == base) || (cyc == base + 25);
      if (cyc == base + 15) START = 1'b0;
      if (cyc == base + 20) START = 1'b1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        act = sample(e.sel);
        total++;
        if (e.due != cyc || act !== e.val) begin
          bad++;
          $display("FAIL %s at +%0d: got %0d expected %0d", e.tag, e.due - base, act, e.val);
        end else $display("check %s ok", e.tag);
      end
      step();
    end
    SYNC_IN = 1'b0;
    // Reset asserted between clock edges must clear outputs without an edge
    #2;
    RST_N = 1'b0;
    #1;
    for (int s = 0; s < 8; s++) begin
      act = sample(sel_t'(s));
      total++;
      if (act !== 8'd0) begin
        bad++;
        $display("FAIL async_reset_out%0d: got %0d expected 0", s, act);
      end else $display("check async_reset_out%0d ok", s);
    end
    #3;
    RST_N = 1'b1;
    step();
    restart(base);
    SYNC_IN = 1'b1;
    step();
    SYNC_IN = 1'b0;
    total++;
    if (TX_SLOT !== 8'd0 || TXSLOT_EN !== 1'b0 || RX_SLOT !== 8'd0 || RXSLOT_EN !== 1'b0 || LOCKED !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_shadow: got tx=%0d/%0d rx=%0d/%0d lock=%0d expected 0/0 0/0 1",
               TX_SLOT, TXSLOT_EN, RX_SLOT, RXSLOT_EN, LOCKED);
    end else $display("check post_reset_shadow ok");
  endtask

  initial begin
    test_reset();
    test_start();
    test_reconfig();
    test_lost_sync();
    test_reject();
    test_resync();
    test_stop_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slot_scheduler.md
SLOT_SCHEDULER -- requirements
Module: slot_scheduler

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 100, the number of slots per frame (legal 2..128).
REQ-002 SHALL have parameter TICK_DIV, default 16, the SYS_CLK cycles per slot (legal >= 2).
REQ-003 SHALL have parameter MISS_MAX, default 4, the number of consecutive frames without SYNC_IN before lock is dropped.
REQ-004 SHALL have port SYS_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port START, input, 1 bit: level run enable.
REQ-007 SHALL have port SYNC_IN, input, 1 bit: single-cycle frame-alignment pulse.
REQ-008 SHALL have port CFG_WE, input, 1 bit: slot configuration write strobe.
REQ-009 SHALL have port CFG_SEL, input, 1 bit: configuration target, 0 = TX, 1 = RX.
REQ-010 SHALL have port CFG_SLOT, input, 8 bits: slot number to write.
REQ-011 SHALL have port CFG_EN, input, 1 bit: slot enable to write.
REQ-012 SHALL have port TIME, output, 7 bits: current slot index.
REQ-013 SHALL have ports TX_SLOT and RX_SLOT, output, 8 bits each: the active slot numbers.
REQ-014 SHALL have ports TXSLOT_EN and RXSLOT_EN, output, 1 bit each: the active slot enables.
REQ-015 SHALL have port FRAME_START, output, 1 bit: one-cycle pulse marking slot 0 of each frame.
REQ-016 SHALL have port LOCKED, output, 1 bit: frame timing aligned to SYNC_IN.
REQ-017 SHALL have port CFG_ERR, output, 1 bit: one-cycle pulse flagging a rejected configuration write.

Function
REQ-018 SHALL register every output, with no combinational path from any input to any output; downstream clock gating depends on glitch-free TIME and enables.
REQ-019 SHALL implement FSM states IDLE, WAIT_SYNC and RUN.
- IDLE -> WAIT_SYNC when START = 1.
- WAIT_SYNC -> RUN on SYNC_IN = 1.
- Any state -> IDLE when START = 0 (takes priority over SYNC_IN).
REQ-020 SHALL, on the WAIT_SYNC->RUN transition from SYNC_IN sampled at cycle N, show at cycle N+1: TIME = 0, internal DIV_CNT = 0, FRAME_START = 1, LOCKED = 1.
REQ-021 SHALL, in RUN, count DIV_CNT 0..TICK_DIV-1 with wrap, so that each TIME value is held for exactly TICK_DIV cycles.
REQ-022 SHALL, in RUN, increment TIME when DIV_CNT = TICK_DIV-1, and wrap TIME from FRAME_LEN-1 to 0.
REQ-023 SHALL assert FRAME_START for exactly the first cycle of each TIME = 0 period.
REQ-024 SHALL treat an in-RUN SYNC_IN as aligned only when sampled with DIV_CNT = TICK_DIV-1 and TIME = FRAME_LEN-1; an aligned SYNC_IN sets LOCKED = 1 and clears the missed-frame counter.
REQ-025 SHALL handle a misaligned in-RUN SYNC_IN as follows: next cycle TIME = 0, DIV_CNT = 0, FRAME_START = 1, LOCKED = 0, missed-frame counter cleared.
REQ-026 SHALL count completed frames with no SYNC_IN; when the count reaches MISS_MAX, LOCKED = 0 while timing continues free-running and the counter saturates.
REQ-027 SHALL, on a CFG_WE write, update the TX shadow (CFG_SEL = 0) or RX shadow (CFG_SEL = 1) slot and enable; a later write in the same frame overwrites an earlier one.
REQ-028 SHALL reject any write with CFG_SLOT >= FRAME_LEN: the shadow is unchanged and CFG_ERR pulses for 1 cycle on the following cycle.
REQ-029 SHALL copy both shadows to TX_SLOT/TXSLOT_EN and RX_SLOT/RXSLOT_EN only on the cycle FRAME_START is asserted, so the active configuration never changes mid-frame.
REQ-030 SHALL, when a CFG_WE write coincides with the frame-start load cycle, apply the written value at the next frame, not the current one.
REQ-031 SHALL force TXSLOT_EN = 0, RXSLOT_EN = 0, TIME = 0, LOCKED = 0 and FRAME_START = 0 in IDLE and WAIT_SYNC, while shadows and active slot numbers are retained.
REQ-032 SHALL, when START drops in RUN, enter IDLE on the next cycle with the REQ-031 output values.

Reset
REQ-033 SHALL, on RST_N = 0 asynchronously, enter IDLE with these values:
- TIME = 0, DIV_CNT = 0, missed-frame counter = 0.
- TX_SLOT = 0, RX_SLOT = 0, and both shadows cleared.
- TXSLOT_EN = 0, RXSLOT_EN = 0.
- FRAME_START = 0, LOCKED = 0, CFG_ERR = 0.
REQ-034 SHALL hold IDLE until the first rising SYS_CLK edge after RST_N deasserts; reset mid-frame discards all timing and shadow state.

Verification (FRAME_LEN = 10, TICK_DIV = 4, MISS_MAX = 2)
REQ-035 Start: START = 1, SYNC_IN pulse at cycle N -> at N+1 TIME = 0 with FRAME_START = 1, TIME = 1 at N+5, TIME = 9 at N+37, TIME = 0 with FRAME_START = 1 at N+41.
REQ-036 Reconfigure: write TX slot 3 with enable 1 mid-frame -> TX_SLOT stays at its old value until the next FRAME_START, then TX_SLOT = 3 and TXSLOT_EN = 1.
REQ-037 Reject: write CFG_SLOT = 10 -> CFG_ERR pulses 1 cycle later and TX_SLOT is unchanged at the next frame.
REQ-038 Resync: in RUN, SYNC_IN at TIME = 5 -> next cycle TIME = 0, FRAME_START = 1, LOCKED = 0; an aligned SYNC_IN one frame later -> LOCKED = 1.
REQ-039 Lost sync: no SYNC_IN for 2 frames -> LOCKED = 0 while TIME keeps cycling 0..9.
REQ-040 Stop and reset: START = 0 mid-frame -> next cycle TIME = 0, both enables = 0; RST_N low mid-frame -> all outputs are 0 immediately, without waiting for a clock edge.
